serial_bcd_addsub: RTL and testbench

Digit-serial BCD adder/subtractor. It processes DPC packed BCD digits per beat, least-significant beat first, with a carry chained across beats. Subtraction uses nine's complement of b plus an injected initial carry. It sits in the BCD arithmetic datapath and generalises the single-digit serial BCD adder: configurable digit width, add/sub mode, valid qualification, stalls, a registered output stream and result flags.

---
 rtl/serial_bcd_addsub_if.sv | 29 ++
 rtl/serial_bcd_addsub.sv | 129 ++++++++++++
 tb/tb_serial_bcd_addsub.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_bcd_addsub_if.sv
// Beat-level bus of the digit-serial BCD adder/subtractor.
// The master drives operand beats; the slave returns result beats and status.
interface serial_bcd_addsub_if #(
    parameter int DPC = 1
);
    logic               in_valid;
    logic               start;
    logic               last;
    logic               sub;
    logic [4*DPC-1:0]   a;
    logic [4*DPC-1:0]   b;
    logic               out_valid;
    logic               out_last;
    logic [4*DPC-1:0]   sum;
    logic               out_carry;
    logic               out_neg;
    logic               out_err;
    logic               busy;

    modport master (
        output in_valid, start, last, sub, a, b,
        input  out_valid, out_last, sum, out_carry, out_neg, out_err, busy
    );

    modport slave (
        input  in_valid, start, last, sub, a, b,
        output out_valid, out_last, sum, out_carry, out_neg, out_err, busy
    );
endinterface

// File: rtl/serial_bcd_addsub.sv
// Digit-serial BCD adder/subtractor: DPC packed digits per beat, LS beat first,
// decimal carry chained across beats, subtraction as a + (9's complement of b) + 1.
module serial_bcd_addsub #(
    parameter int DPC = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    serial_bcd_addsub_if.slave   bus
);
    localparam int W = 4 * DPC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           carry_q, carry_d;
    logic           mode_q, mode_d;
    logic           err_q, err_d;

    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           out_carry_q, out_carry_d;
    logic           out_neg_q, out_neg_d;
    logic           out_err_q, out_err_d;

    logic           accept;
    logic           mode_cur;
    logic [W-1:0]   digits;
    logic           cout;
    logic           beat_err;
    logic           err_acc;
    logic           c;
    logic [3:0]     ai, bi, bb;
    logic [4:0]     s;

    // A start beat is always taken (fresh operation or restart); plain beats only inside one.
    assign accept   = bus.in_valid && (bus.start || (state_q == RUN));
    assign mode_cur = bus.start ? bus.sub : mode_q;

    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        digits   = '0;
        beat_err = 1'b0;
        c        = bus.start ? bus.sub : carry_q;
        ai       = '0;
        bi       = '0;
        bb       = '0;
        s        = '0;
        for (int i = 0; i < DPC; i++) begin
            ai       = bus.a[4*i +: 4];
            bi       = bus.b[4*i +: 4];
            beat_err = beat_err | (ai > 4'd9) | (bi > 4'd9);
            bb       = mode_cur ? 4'(4'd9 - bi) : bi;
            s        = {1'b0, ai} + {1'b0, bb} + {4'b0, c};
            if (s > 5'd9) begin
                digits[4*i +: 4] = 4'(s + 5'd6);
                c                = 1'b1;
            end else begin
                digits[4*i +: 4] = s[3:0];
                c                = 1'b0;
            end
        end
        cout    = c;
        err_acc = (bus.start ? 1'b0 : err_q) | beat_err;
    end

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        mode_d      = mode_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_last_d  = out_last_q;
        sum_d       = sum_q;
        out_carry_d = out_carry_q;
        out_neg_d   = out_neg_q;
        out_err_d   = out_err_q;
        if (accept) begin
            state_d     = bus.last ? IDLE : RUN;
            carry_d     = cout;
            mode_d      = mode_cur;
            err_d       = bus.last ? 1'b0 : err_acc;
            out_valid_d = 1'b1;
            out_last_d  = bus.last;
            sum_d       = digits;
            out_carry_d = bus.last & cout;
            out_neg_d   = bus.last & mode_cur & ~cout;
            out_err_d   = err_acc;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sum_q       <= '0;
            out_carry_q <= 1'b0;
            out_neg_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sum_q       <= sum_d;
            out_carry_q <= out_carry_d;
            out_neg_q   <= out_neg_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.sum       = sum_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_neg   = out_neg_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state_q == RUN);
endmodule

// File: tb/tb_serial_bcd_addsub.sv
// Directed bench for serial_bcd_addsub: a DPC=1 and a DPC=2 instance,
// hand-computed result streams, stalls, ignored beats, restart, error flag and async reset.
module tb_serial_bcd_addsub;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    serial_bcd_addsub_if #(.DPC(1)) if1 ();
    serial_bcd_addsub_if #(.DPC(2)) if2 ();

    serial_bcd_addsub #(.DPC(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
    serial_bcd_addsub #(.DPC(2)) dut2 (.clk(clk), .rstn(rstn), .bus(if2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One DPC=1 beat: drive, clock, then check the registered result one step after the edge.
    task automatic beat1(input string tag, input logic st, input logic la, input logic sb,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] e_sum, input logic e_last, input logic e_carry,
                         input logic e_neg, input logic e_err, input logic e_busy);
        if1.in_valid = 1'b1; if1.start = st; if1.last = la; if1.sub = sb;
        if1.a = a; if1.b = b;
        @(posedge clk); #1;
        if1.in_valid = 1'b0; if1.start = 1'b0; if1.last = 1'b0;
        check({tag, ".valid"}, 32'(if1.out_valid), 32'd1);
        check({tag, ".sum"},   32'(if1.sum),       32'(e_sum));
        check({tag, ".last"},  32'(if1.out_last),  32'(e_last));
        check({tag, ".carry"}, 32'(if1.out_carry), 32'(e_carry));
        check({tag, ".neg"},   32'(if1.out_neg),   32'(e_neg));
        check({tag, ".err"},   32'(if1.out_err),   32'(e_err));
        check({tag, ".busy"},  32'(if1.busy),      32'(e_busy));
    endtask

    task automatic beat2(input string tag, input logic st, input logic la,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e_sum, input logic e_last, input logic e_carry,
                         input logic e_busy);
        if2.in_valid = 1'b1; if2.start = st; if2.last = la; if2.sub = 1'b0;
        if2.a = a; if2.b = b;
        @(posedge clk); #1;
        if2.in_valid = 1'b0; if2.start = 1'b0; if2.last = 1'b0;
        check({tag, ".valid"}, 32'(if2.out_valid), 32'd1);
        check({tag, ".sum"},   32'(if2.sum),       32'(e_sum));
        check({tag, ".last"},  32'(if2.out_last),  32'(e_last));
        check({tag, ".carry"}, 32'(if2.out_carry), 32'(e_carry));
        check({tag, ".neg"},   32'(if2.out_neg),   32'd0);
        check({tag, ".busy"},  32'(if2.busy),      32'(e_busy));
    endtask

    // Idle cycle on DUT1: no result pulse, outputs hold, busy as given.
    task automatic stall1(input string tag, input logic [3:0] e_sum, input logic e_busy);
        if1.in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".valid"}, 32'(if1.out_valid), 32'd0);
        check({tag, ".sum"},   32'(if1.sum),       32'(e_sum));
        check({tag, ".busy"},  32'(if1.busy),      32'(e_busy));
    endtask

    initial begin
        if1.in_valid = 1'b0; if1.start = 1'b0; if1.last = 1'b0; if1.sub = 1'b0;
        if1.a = '0; if1.b = '0;
        if2.in_valid = 1'b0; if2.start = 1'b0; if2.last = 1'b0; if2.sub = 1'b0;
        if2.a = '0; if2.b = '0;

        #12;
        check("rst.valid", 32'(if1.out_valid), 32'd0);
        check("rst.sum",   32'(if1.sum),       32'd0);
        check("rst.flags", 32'({if1.out_last, if1.out_carry, if1.out_neg, if1.out_err}), 32'd0);
        check("rst.busy",  32'(if1.busy),      32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // 123 + 480 = 603
        beat1("add0", 1, 0, 0, 4'd3, 4'd0, 4'd3, 0, 0, 0, 0, 1);
        beat1("add1", 0, 0, 0, 4'd2, 4'd8, 4'd0, 0, 0, 0, 0, 1);
        beat1("add2", 0, 1, 0, 4'd1, 4'd4, 4'd6, 1, 0, 0, 0, 0);

        // 405 - 123 = 282
        beat1("subp0", 1, 0, 1, 4'd5, 4'd3, 4'd2, 0, 0, 0, 0, 1);
        beat1("subp1", 0, 0, 0, 4'd0, 4'd2, 4'd8, 0, 0, 0, 0, 1);
        beat1("subp2", 0, 1, 0, 4'd4, 4'd1, 4'd2, 1, 1, 0, 0, 0);

        // 123 - 405 = -282 -> ten's complement 718
        beat1("subn0", 1, 0, 1, 4'd3, 4'd5, 4'd8, 0, 0, 0, 0, 1);
        beat1("subn1", 0, 0, 0, 4'd2, 4'd0, 4'd1, 0, 0, 0, 0, 1);
        beat1("subn2", 0, 1, 0, 4'd1, 4'd4, 4'd7, 1, 0, 1, 0, 0);

        // DPC=2: 9999 + 0001 = 1_0000, then single-beat 45 + 38 = 83
        beat2("w0", 1, 0, 8'h99, 8'h01, 8'h00, 0, 0, 1);
        beat2("w1", 0, 1, 8'h99, 8'h00, 8'h00, 1, 1, 0);
        beat2("ws", 1, 1, 8'h45, 8'h38, 8'h83, 1, 0, 0);

        // Test 1 again with 3 stall cycles between beats
        beat1("stl0", 1, 0, 0, 4'd3, 4'd0, 4'd3, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) stall1($sformatf("gapA%0d", i), 4'd3, 1'b1);
        beat1("stl1", 0, 0, 0, 4'd2, 4'd8, 4'd0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) stall1($sformatf("gapB%0d", i), 4'd0, 1'b1);
        beat1("stl2", 0, 1, 0, 4'd1, 4'd4, 4'd6, 1, 0, 0, 0, 0);

        // Non-start beat while idle is ignored
        if1.in_valid = 1'b1; if1.start = 1'b0; if1.last = 1'b0; if1.a = 4'd5; if1.b = 4'd5;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        check("ign.valid", 32'(if1.out_valid), 32'd0);
        check("ign.busy",  32'(if1.busy),      32'd0);
        check("ign.sum",   32'(if1.sum),       32'd6);

        // Restart: 7+5 abandoned, fresh 1+1 must not see the pending carry
        beat1("rs0", 1, 0, 0, 4'd7, 4'd5, 4'd2, 0, 0, 0, 0, 1);
        beat1("rs1", 1, 1, 0, 4'd1, 4'd1, 4'd2, 1, 0, 0, 0, 0);

        // Non-BCD digit: error sticks for the operation, cleared for the next one
        beat1("er0", 1, 0, 0, 4'hA, 4'd0, 4'd0, 0, 0, 0, 1, 1);
        beat1("er1", 0, 1, 0, 4'd1, 4'd1, 4'd3, 1, 0, 0, 1, 0);
        beat1("er2", 1, 1, 0, 4'd2, 4'd3, 4'd5, 1, 0, 0, 0, 0);

        // Async reset after the 2nd beat of test 1
        beat1("rb0", 1, 0, 0, 4'd3, 4'd0, 4'd3, 0, 0, 0, 0, 1);
        beat1("rb1", 0, 0, 0, 4'd2, 4'd8, 4'd0, 0, 0, 0, 0, 1);
        #2 rstn = 1'b0;
        #1;
        check("arst.valid", 32'(if1.out_valid), 32'd0);
        check("arst.sum",   32'(if1.sum),       32'd0);
        check("arst.flags", 32'({if1.out_last, if1.out_carry, if1.out_neg, if1.out_err}), 32'd0);
        check("arst.busy",  32'(if1.busy),      32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        beat1("ra0", 1, 0, 0, 4'd3, 4'd0, 4'd3, 0, 0, 0, 0, 1);
        beat1("ra1", 0, 0, 0, 4'd2, 4'd8, 4'd0, 0, 0, 0, 0, 1);
        beat1("ra2", 0, 1, 0, 4'd1, 4'd4, 4'd6, 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
